// File: rtl/kf_priority_interrupt_unit.sv
// Rotating-priority interrupt unit (IRR/ISR, ack, EOI); int_out 1 cycle after IRR, ack_valid 1 cycle after ack_req,
// ack_req ignored while a response is in flight. Define KF_PRIORITY_AUTO_EOI_EN for auto-EOI (ack does not set ISR).
module kf_priority_interrupt_unit #(
   parameter int NUM_IRQ = 16,
   parameter int ID_W    = $clog2(NUM_IRQ)
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [NUM_IRQ-1:0] irq_in,
   input  logic [NUM_IRQ-1:0] edge_mode,
   input  logic [NUM_IRQ-1:0] irq_mask,
   input  logic               special_mask,
   input  logic               rotate_on_eoi,
   input  logic               set_bottom_valid,
   input  logic [ID_W-1:0]    set_bottom_id,
   output logic               int_out,
   input  logic               ack_req,
   output logic               ack_valid,
   output logic [ID_W-1:0]    ack_id,
   output logic               ack_spurious,
   input  logic               eoi_valid,
   input  logic               eoi_specific,
   input  logic [ID_W-1:0]    eoi_id,
   output logic [NUM_IRQ-1:0] isr_out,
   output logic [NUM_IRQ-1:0] irr_out
);

   typedef enum logic {ST_IDLE, ST_RESP} state_t;

   localparam logic [ID_W:0] NONE = (ID_W+1)'(NUM_IRQ);

   // Position 0 is the channel just above the bottom pointer; NONE when no bit is set.
   function automatic logic [ID_W:0] first_pos(input logic [NUM_IRQ-1:0] v, input logic [ID_W-1:0] b);
      logic [ID_W:0]   pos;
      logic [ID_W-1:0] idx;
      pos = NONE;
      for (int p = NUM_IRQ - 1; p >= 0; p--) begin
         idx = b + ID_W'(p) + ID_W'(1);
         if (v[idx]) pos = (ID_W+1)'(p);
      end
      return pos;
   endfunction

   function automatic logic [NUM_IRQ-1:0] onehot(input logic [ID_W-1:0] id);
      return {{(NUM_IRQ-1){1'b0}}, 1'b1} << id;
   endfunction

   state_t               state_q, state_d;
   logic [NUM_IRQ-1:0]   irr_q, irr_d, isr_q, isr_d, hist_q;
   logic [ID_W-1:0]      bot_q, bot_d, ack_id_q, ack_id_d;
   logic                 int_q, ack_sp_q, ack_sp_d;

   logic [NUM_IRQ-1:0]   blk_v, eoi_clr, irr_clr;
   logic [ID_W:0]        win_pos, blk_pos, top_pos;
   logic [ID_W-1:0]      win_id, top_id;
   logic                 win_vld, ack_take, grant, eoi_rot;

   always_comb begin
      blk_v   = special_mask ? (isr_q & ~irq_mask) : isr_q;
      win_pos = first_pos(irr_q & ~irq_mask, bot_q);
      blk_pos = first_pos(blk_v, bot_q);
      top_pos = first_pos(isr_q, bot_q);
      win_vld = (win_pos < blk_pos);
      win_id  = bot_q + win_pos[ID_W-1:0] + ID_W'(1);
      top_id  = bot_q + top_pos[ID_W-1:0] + ID_W'(1);
   end

   always_comb begin
      state_d  = state_q;
      ack_id_d = ack_id_q;
      ack_sp_d = ack_sp_q;
      ack_take = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (ack_req) begin
               ack_take = 1'b1;
               state_d  = ST_RESP;
               ack_id_d = win_vld ? win_id : bot_q;
               ack_sp_d = ~win_vld;
            end
         end
         ST_RESP: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      grant   = ack_take & win_vld;
      eoi_clr = '0;
      eoi_rot = 1'b0;
      if (eoi_valid) begin
         if (eoi_specific) begin
            eoi_clr = onehot(eoi_id);
         end else if (top_pos != NONE) begin
            eoi_clr = onehot(top_id);
            eoi_rot = rotate_on_eoi;
         end
      end
      bot_d = eoi_rot ? top_id : bot_q;
`ifdef KF_PRIORITY_AUTO_EOI_EN
      isr_d = isr_q & ~eoi_clr;
      if (grant && rotate_on_eoi) bot_d = win_id;
`else
      // The ack's set is applied after the EOI clear so it wins on the same bit.
      isr_d = (isr_q & ~eoi_clr) | (grant ? onehot(win_id) : '0);
`endif
      if (set_bottom_valid) bot_d = set_bottom_id;
      irr_clr = grant ? (onehot(win_id) & edge_mode) : '0;
      irr_d   = (edge_mode & ((irr_q & ~irr_clr) | (irq_in & ~hist_q))) | (~edge_mode & irq_in);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         irr_q    <= '0;
         isr_q    <= '0;
         hist_q   <= '0;
         bot_q    <= ID_W'(NUM_IRQ - 1);
         ack_id_q <= '0;
         ack_sp_q <= 1'b0;
         int_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         irr_q    <= irr_d;
         isr_q    <= isr_d;
         hist_q   <= irq_in;
         bot_q    <= bot_d;
         ack_id_q <= ack_id_d;
         ack_sp_q <= ack_sp_d;
         int_q    <= win_vld;
      end
   end

   assign int_out      = int_q;
   assign ack_valid    = (state_q == ST_RESP);
   assign ack_id       = ack_id_q;
   assign ack_spurious = ack_sp_q;
   assign isr_out      = isr_q;
   assign irr_out      = irr_q;

endmodule

// File: tb/tb_kf_priority_interrupt_unit.sv
// Bench for kf_priority_interrupt_unit (NUM_IRQ=16): cycle model checked every negedge plus directed literal checks.
module tb_kf_priority_interrupt_unit;
   localparam int N = 16;
`ifdef KF_PRIORITY_AUTO_EOI_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic [N-1:0] irq_in = '0, edge_mode = 16'hFFDF, irq_mask = '0;
   logic special_mask = 0, rotate_on_eoi = 0, set_bottom_valid = 0, ack_req = 0;
   logic eoi_valid = 0, eoi_specific = 0;
   logic [3:0] set_bottom_id = '0, eoi_id = '0;
   logic int_out, ack_valid, ack_spurious;
   logic [3:0] ack_id;
   logic [N-1:0] isr_out, irr_out;

   kf_priority_interrupt_unit #(.NUM_IRQ(N)) dut (
      .clock(clock), .reset(reset), .irq_in(irq_in), .edge_mode(edge_mode), .irq_mask(irq_mask),
      .special_mask(special_mask), .rotate_on_eoi(rotate_on_eoi), .set_bottom_valid(set_bottom_valid),
      .set_bottom_id(set_bottom_id), .int_out(int_out), .ack_req(ack_req), .ack_valid(ack_valid),
      .ack_id(ack_id), .ack_spurious(ack_spurious), .eoi_valid(eoi_valid), .eoi_specific(eoi_specific),
      .eoi_id(eoi_id), .isr_out(isr_out), .irr_out(irr_out));

   always #5 clock = ~clock;

   int n_cmp = 0, n_bad = 0;
   bit run = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: walks priority order from bottom+1 upwards, one update per clock.
   logic [N-1:0] m_irr, m_isr, m_hist, req_m, blk_m, nirr, nisr;
   int  m_bot, nbot, m_aid, kw, kb, ki, wid, tid, ch;
   bit  m_int, m_av, m_asp, win, take;

   always @(posedge clock) begin
      if (reset) begin
         m_irr = '0; m_isr = '0; m_hist = '0; m_bot = N - 1;
         m_int = 0; m_av = 0; m_asp = 0; m_aid = 0;
      end else begin
         req_m = m_irr & ~irq_mask;
         blk_m = special_mask ? (m_isr & ~irq_mask) : m_isr;
         kw = N + 1; kb = N + 1; ki = N + 1; wid = 0; tid = 0;
         for (int k = N; k >= 1; k--) begin
            ch = (m_bot + k) % N;
            if (req_m[ch]) begin kw = k; wid = ch; end
            if (blk_m[ch]) kb = k;
            if (m_isr[ch]) begin ki = k; tid = ch; end
         end
         win  = (kw < kb);
         take = ack_req && !m_av;
         nisr = m_isr; nirr = m_irr; nbot = m_bot;
         if (eoi_valid) begin
            if (eoi_specific) nisr[eoi_id] = 1'b0;
            else if (ki <= N) begin
               nisr[tid] = 1'b0;
               if (rotate_on_eoi) nbot = tid;
            end
         end
         if (take && win) begin
            if (!AUTO) nisr[wid] = 1'b1;
            if (edge_mode[wid]) nirr[wid] = 1'b0;
            if (AUTO && rotate_on_eoi) nbot = wid;
         end
         if (set_bottom_valid) nbot = set_bottom_id;
         for (int i = 0; i < N; i++) begin
            if (edge_mode[i]) begin
               if (irq_in[i] && !m_hist[i]) nirr[i] = 1'b1;
            end else nirr[i] = irq_in[i];
         end
         if (take) begin
            m_aid = win ? wid : m_bot;
            m_asp = !win;
         end
         m_av = take; m_int = win;
         m_irr = nirr; m_isr = nisr; m_bot = nbot; m_hist = irq_in;
      end
   end

   always @(negedge clock) begin
      if (run) begin
         chk("int_out", 64'(int_out), 64'(m_int));
         chk("ack_valid", 64'(ack_valid), 64'(m_av));
         chk("irr_out", 64'(irr_out), 64'(m_irr));
         chk("isr_out", 64'(isr_out), 64'(m_isr));
         if (m_av) begin
            chk("ack_id", 64'(ack_id), 64'(m_aid));
            chk("ack_spurious", 64'(ack_spurious), 64'(m_asp));
         end
      end
   end

   task automatic tick;
      @(posedge clock);
      #2;
   endtask

   task automatic do_ack(output logic [3:0] id, output logic sp);
      bit got;
      got = 0; id = '0; sp = 1'b0;
      ack_req = 1; tick; ack_req = 0;
      for (int i = 0; i < 4 && !got; i++) begin
         if (ack_valid) begin got = 1; id = ack_id; sp = ack_spurious; end
         else tick;
      end
      if (!got) begin
         n_cmp++; n_bad++;
         $display("FAIL ack_timeout: got no ack_valid expected pulse within 4 cycles");
      end
      tick;
   endtask

   task automatic eoi(input logic spec, input logic [3:0] id);
      eoi_valid = 1; eoi_specific = spec; eoi_id = id; tick;
      eoi_valid = 0; eoi_specific = 0; tick;
   endtask

   logic [3:0] id;
   logic       sp;

   initial begin
      tick; run = 1; tick; tick;
      reset = 0; tick;
      chk("rst_int_out", 64'(int_out), 0);
      chk("rst_ack_valid", 64'(ack_valid), 0);
      chk("rst_ack_id", 64'(ack_id), 0);
      chk("rst_ack_spurious", 64'(ack_spurious), 0);
      chk("rst_irr", 64'(irr_out), 0);
      chk("rst_isr", 64'(isr_out), 0);

      // Level ch5 raised and dropped before ack: spurious, id = bottom (15)
      irq_in = 16'h0020; tick;
      chk("lvl_irr", 64'(irr_out), 64'h0020);
      irq_in = 16'h0000; tick; tick;
      chk("lvl_int_drop", 64'(int_out), 0);
      do_ack(id, sp);
      chk("lvl_spurious", 64'(sp), 1);
      chk("lvl_spur_id", 64'(id), 15);
      chk("lvl_isr", 64'(isr_out), 0);

`ifdef KF_PRIORITY_AUTO_EOI_EN
      irq_in = 16'h0010; tick; tick;
      do_ack(id, sp);
      chk("auto_id", 64'(id), 4);
      chk("auto_isr", 64'(isr_out), 0);
      chk("auto_irr", 64'(irr_out), 0);
      irq_in = 16'h0000; tick;
      irq_in = 16'h0010; tick; tick;
      chk("auto_int_again", 64'(int_out), 1);
      do_ack(id, sp);
      chk("auto_regrant", 64'(id), 4);
      chk("auto_regrant_sp", 64'(sp), 0);
      irq_in = 16'h0000; tick;
`else
      // Edge ch3+ch9
      irq_in = 16'h0208; tick;
      chk("edge_irr", 64'(irr_out), 64'h0208);
      chk("edge_int_lat", 64'(int_out), 0);
      tick;
      chk("edge_int", 64'(int_out), 1);
      do_ack(id, sp);
      chk("edge_ack3", 64'(id), 3);
      chk("edge_sp3", 64'(sp), 0);
      chk("edge_isr3", 64'(isr_out), 64'h0008);
      chk("edge_irr9", 64'(irr_out), 64'h0200);
      chk("edge_blocked", 64'(int_out), 0);
      do_ack(id, sp);
      chk("edge_blk_sp", 64'(sp), 1);
      eoi(1'b0, 4'd0);
      chk("edge_eoi_isr", 64'(isr_out), 0);
      do_ack(id, sp);
      chk("edge_ack9", 64'(id), 9);
      irq_in = 16'h0000;
      eoi(1'b0, 4'd0);
      chk("edge_isr_clear", 64'(isr_out), 0);

      // Rotation on non-specific EOI
      rotate_on_eoi = 1;
      irq_in = 16'h0001; tick; tick;
      do_ack(id, sp);
      chk("rot_ack0", 64'(id), 0);
      eoi(1'b0, 4'd0);
      irq_in = 16'h0000; tick;
      irq_in = 16'h0003; tick; tick;
      do_ack(id, sp);
      chk("rot_ack1", 64'(id), 1);
      eoi(1'b0, 4'd0);
      do_ack(id, sp);
      chk("rot_ack0_last", 64'(id), 0);
      // Rotating EOI and set_bottom together: set_bottom wins
      eoi_valid = 1; set_bottom_valid = 1; set_bottom_id = 4'd15; tick;
      eoi_valid = 0; set_bottom_valid = 0; tick;
      chk("rot_isr_clear", 64'(isr_out), 0);
      irq_in = 16'h0000; rotate_on_eoi = 0; tick;
      do_ack(id, sp);
      chk("setbot_sp", 64'(sp), 1);
      chk("setbot_id", 64'(id), 15);

      // Special mask
      irq_in = 16'h0004; tick; tick;
      do_ack(id, sp);
      chk("sm_ack2", 64'(id), 2);
      irq_mask = 16'h0004; irq_in = 16'h0044; tick; tick;
      chk("sm_off_int", 64'(int_out), 0);
      special_mask = 1; tick; tick;
      chk("sm_on_int", 64'(int_out), 1);
      do_ack(id, sp);
      chk("sm_ack6", 64'(id), 6);
      chk("sm_isr", 64'(isr_out), 64'h0044);
      eoi(1'b1, 4'd2);
      eoi(1'b1, 4'd2);
      chk("sm_spec_eoi", 64'(isr_out), 64'h0040);
      eoi(1'b1, 4'd6);
      chk("sm_isr_clear", 64'(isr_out), 0);
      irq_mask = '0; special_mask = 0; irq_in = '0; tick;
`endif

      // Reset coincident with ack sample: no ack_valid
      irq_in = 16'h0100; tick; tick;
      ack_req = 1; reset = 1; tick; ack_req = 0;
      chk("rst_mid_vld", 64'(ack_valid), 0);
      tick;
      chk("rst_mid_vld2", 64'(ack_valid), 0);
      chk("rst_mid_irr", 64'(irr_out), 0);
      reset = 0; irq_in = '0; tick; tick;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected end of test");
      $fatal(1);
   end
endmodule
